// File: rtl/scan_select_mux.sv
// scan_select_mux: registered N-channel word selector with manual select and round-robin auto-scan
module scan_select_mux #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      hold,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          y_sel,
  output logic                      y_valid,
  output logic                      wrap
);
  typedef enum logic {MANUAL, SCAN} state_t;
  state_t state;
  logic [15:0] cnt, nxt_cnt;
  logic [SEL_W-1:0] idx, nxt_idx;
  logic [WIDTH-1:0] words [2**SEL_W];
  logic entering, last_cnt, last_idx, adv, sel_ok;
  // unused select codes read as zero so every index stays in range
  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_w
    if (i < CHANNELS) begin : g_v
      assign words[i] = data_in[i*WIDTH +: WIDTH];
    end else begin : g_z
      assign words[i] = '0;
    end
  end
  always_comb begin
    entering = state == MANUAL;
    last_cnt = cnt == 16'(DWELL - 1);
    last_idx = idx == SEL_W'(CHANNELS - 1);
    adv      = !entering && !hold && last_cnt;
    nxt_cnt  = entering ? '0 : hold ? cnt : last_cnt ? '0 : cnt + 16'd1;
    nxt_idx  = entering ? '0 : adv ? (last_idx ? '0 : idx + SEL_W'(1)) : idx;
    sel_ok   = 32'(sel) < CHANNELS;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MANUAL;
      cnt     <= '0;
      idx     <= '0;
      y       <= '0;
      y_sel   <= '0;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
    end else if (!mode) begin
      state   <= MANUAL;
      cnt     <= '0;
      idx     <= '0;
      wrap    <= 1'b0;
      y_valid <= sel_ok;
      if (sel_ok) begin
        y     <= words[sel];
        y_sel <= sel;
      end
    end else begin
      state   <= SCAN;
      cnt     <= nxt_cnt;
      idx     <= nxt_idx;
      y       <= words[nxt_idx];
      y_sel   <= nxt_idx;
      y_valid <= 1'b1;
      wrap    <= adv && last_idx;
    end
  end
endmodule

// File: tb/tb_scan_select_mux.sv
// tb_scan_select_mux: checks a 4-channel/dwell-3 and a 3-channel/dwell-1 selector against a step-count model
module tb_scan_select_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b1, mode_a = 1'b1, hold_a = 1'b0, rst_b = 1'b1, mode_b = 1'b1, hold_b = 1'b0;
  logic [1:0] sel_a = 2'd2, sel_b = 2'd0;
  logic [19:0] d_a = {5'h1F, 5'h15, 5'h0A, 5'h01};
  logic [14:0] d_b = {5'h15, 5'h0A, 5'h01};
  logic [4:0] ya, yb;
  logic [1:0] ysa, ysb;
  logic yva, yvb, wa, wb;
  int checks = 0, errors = 0;
  bit m_scan [2];
  int m_t [2];
  logic [4:0] m_y [2];
  logic [1:0] m_sel [2];
  logic m_valid [2], m_wrap [2];

  scan_select_mux #(.WIDTH(5), .CHANNELS(4), .SEL_W(2), .DWELL(3)) dut_a (
    .clk(clk), .rst(rst_a), .data_in(d_a), .mode(mode_a), .sel(sel_a), .hold(hold_a),
    .y(ya), .y_sel(ysa), .y_valid(yva), .wrap(wa));
  scan_select_mux #(.WIDTH(5), .CHANNELS(3), .SEL_W(2), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst_b), .data_in(d_b), .mode(mode_b), .sel(sel_b), .hold(hold_b),
    .y(yb), .y_sel(ysb), .y_valid(yvb), .wrap(wb));

  // Scan position is the count t of unheld scan steps since entry: channel = (t/dwell)%channels
  task automatic model(input int k, input int c, input int dw, input logic r, input logic md,
                       input logic [1:0] s, input logic h, input logic [19:0] d);
    if (r) begin
      m_scan[k] = 0; m_t[k] = 0; m_y[k] = 0; m_sel[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
    end else if (!md) begin
      m_scan[k] = 0; m_wrap[k] = 0;
      m_valid[k] = int'(s) < c;
      if (int'(s) < c) begin m_y[k] = d[int'(s)*5 +: 5]; m_sel[k] = s; end
    end else begin
      if (!m_scan[k]) begin m_t[k] = 0; m_wrap[k] = 0; end
      else if (h) m_wrap[k] = 0;
      else begin m_t[k]++; m_wrap[k] = (m_t[k] % (dw * c)) == 0; end
      m_scan[k] = 1;
      m_sel[k] = 2'((m_t[k] / dw) % c);
      m_y[k] = d[int'(m_sel[k])*5 +: 5];
      m_valid[k] = 1;
    end
  endtask

  task automatic cycle;
    @(posedge clk);
    model(0, 4, 3, rst_a, mode_a, sel_a, hold_a, d_a);
    model(1, 3, 1, rst_b, mode_b, sel_b, hold_b, {5'b0, d_b});
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if ({ya, ysa, yva, wa} !== 9'b0 || {yb, ysb, yvb, wb} !== 9'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: a=%h/%0d/%b/%b b=%h/%0d/%b/%b, want all 0", i, ya, ysa, yva, wa, yb, ysb, yvb, wb);
      end
    end
  endtask

  task automatic test_manual;
    logic [1:0] s [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
    logic [4:0] w [4] = '{5'h1F, 5'h0A, 5'h01, 5'h15};
    rst_a = 0; mode_a = 0;
    for (int i = 0; i < 4; i++) begin
      sel_a = s[i];
      cycle();
      checks++;
      if (ya !== w[i] || ysa !== s[i] || yva !== 1'b1 || wa !== 1'b0) begin
        errors++;
        $display("FAIL manual sel=%0d: y=%h y_sel=%0d valid=%b wrap=%b, want %h %0d 1 0", s[i], ya, ysa, yva, wa, w[i], s[i]);
      end
    end
  endtask

  task automatic test_scan;
    int exp_sel [15] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};
    rst_a = 1; mode_a = 1;
    cycle();
    rst_a = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      checks++;
      if (int'(ysa) != exp_sel[i] || ya !== d_a[exp_sel[i]*5 +: 5] || yva !== 1'b1 || wa !== (i == 12)) begin
        errors++;
        $display("FAIL scan cyc%0d: y_sel=%0d y=%h valid=%b wrap=%b, want %0d %h 1 %b", i + 1, ysa, ya, yva, wa,
                 exp_sel[i], d_a[exp_sel[i]*5 +: 5], i == 12);
      end
    end
  endtask

  task automatic test_hold;
    int n = 0;
    while (ysa !== 2'd2 && n < 20) begin cycle(); n++; end
    checks++;
    if (ysa !== 2'd2) begin errors++; $display("FAIL hold_reach: y_sel=%0d never reached 2", ysa); end
    hold_a = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (ysa !== 2'd2 || ya !== 5'h15 || wa !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc%0d: y_sel=%0d y=%h wrap=%b, want 2 15 0", i, ysa, ya, wa);
      end
    end
    hold_a = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (ysa !== (i < 2 ? 2'd2 : 2'd3)) begin
        errors++;
        $display("FAIL hold_release cyc%0d: y_sel=%0d, want %0d", i, ysa, i < 2 ? 2 : 3);
      end
    end
  endtask

  task automatic test_mode_switch;
    logic [1:0] exp_sel [6] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
    int n = 0;
    while (ysa !== 2'd1 && n < 20) begin cycle(); n++; end
    checks++;
    if (ysa !== 2'd1) begin errors++; $display("FAIL switch_reach: y_sel=%0d never reached 1", ysa); end
    mode_a = 0; sel_a = 2'd3;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) mode_a = 1;
      cycle();
      checks++;
      if (ysa !== exp_sel[i] || ya !== d_a[int'(exp_sel[i])*5 +: 5] || yva !== 1'b1) begin
        errors++;
        $display("FAIL mode_switch cyc%0d: y_sel=%0d y=%h valid=%b, want %0d", i, ysa, ya, yva, exp_sel[i]);
      end
    end
  endtask

  task automatic test_small_config;
    logic [4:0] py;
    logic [1:0] ps;
    rst_b = 1; mode_b = 1;
    cycle();
    rst_b = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (int'(ysb) != i % 3 || yb !== d_b[(i % 3)*5 +: 5] || wb !== (i == 3)) begin
        errors++;
        $display("FAIL small_scan cyc%0d: y_sel=%0d y=%h wrap=%b, want %0d %h %b", i, ysb, yb, wb, i % 3, d_b[(i % 3)*5 +: 5], i == 3);
      end
    end
    d_b[14:10] = 5'h07;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (ysb === 2'd2 && yb !== 5'h07) begin
        errors++;
        $display("FAIL small_live: y=%h, want 07", yb);
      end else if (ysb !== 2'd2 && i == 2) begin
        errors++;
        $display("FAIL small_live: y_sel=%0d, want 2", ysb);
      end
    end
    py = yb; ps = ysb;
    mode_b = 0; sel_b = 2'd3;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (yb !== py || ysb !== ps || yvb !== 1'b0 || wb !== 1'b0) begin
        errors++;
        $display("FAIL small_oor cyc%0d: y=%h y_sel=%0d valid=%b, want %h %0d 0", i, yb, ysb, yvb, py, ps);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      rst_a = ($urandom % 40) == 0; rst_b = ($urandom % 40) == 0;
      if ($urandom % 12 == 0) mode_a = ~mode_a;
      if ($urandom % 12 == 0) mode_b = ~mode_b;
      hold_a = ($urandom % 4) == 0; hold_b = ($urandom % 4) == 0;
      sel_a = 2'($urandom); sel_b = 2'($urandom);
      if ($urandom % 4 == 0) d_a = 20'($urandom);
      if ($urandom % 4 == 0) d_b = 15'($urandom);
      cycle();
      checks++;
      if (ya !== m_y[0] || ysa !== m_sel[0] || yva !== m_valid[0] || wa !== m_wrap[0]) begin
        errors++;
        $display("FAIL random_a cyc%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", i, ya, ysa, yva, wa, m_y[0], m_sel[0], m_valid[0], m_wrap[0]);
      end
      checks++;
      if (yb !== m_y[1] || ysb !== m_sel[1] || yvb !== m_valid[1] || wb !== m_wrap[1]) begin
        errors++;
        $display("FAIL random_b cyc%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b", i, yb, ysb, yvb, wb, m_y[1], m_sel[1], m_valid[1], m_wrap[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_hold();
    test_mode_switch();
    test_small_config();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_select_mux.md
Name: scan_select_mux

Overview:
- Registered, parametrised N-channel word selector: successor to the fixed 4:1 5-bit combinational selector.
- Two modes:
  - Manual: the external select chooses the channel.
  - Auto-scan: an internal dwell counter steps through the channels round-robin.
- Feeds the display/output stage, which time-multiplexes several data words onto one bus.
- Output is registered and tagged with channel index, valid and wrap strobes.

Parameters:
WIDTH, 5, bits per channel word
CHANNELS, 4, number of input channels (2..16)
SEL_W, 2, select/index width; must satisfy 2**SEL_W >= CHANNELS
DWELL, 4, clock cycles each channel is presented in scan mode (1..65535)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
data_in  input  CHANNELS*WIDTH  flattened channel words; channel i = data_in[i*WIDTH +: WIDTH]
mode  input  1  0 = manual select, 1 = auto-scan
sel  input  SEL_W  manual channel select
hold  input  1  freeze scan position (scan mode only)
y  output  WIDTH  selected word, registered
y_sel  output  SEL_W  channel index that y was taken from
y_valid  output  1  y/y_sel carry a legal channel
wrap  output  1  one-cycle pulse when scan index wraps CHANNELS-1 -> 0

Behaviour:
- Reset (rst=1 at a clock edge):
  - Outputs: y=0, y_sel=0, y_valid=0, wrap=0.
  - Internal state: dwell counter=0, scan index=0, state=MANUAL.
  - Reset overrides every other input.
  - Reset mid-scan abandons the position; the first post-reset cycle applies `mode` as sampled then.
- Latency: 1 cycle. Inputs sampled at edge k appear on outputs after edge k. No combinational input-to-output path.
- State machine, states MANUAL and SCAN:
  - MANUAL -> SCAN when mode=1.
  - SCAN -> MANUAL when mode=0.
  - The state register follows `mode` every cycle.
- MANUAL, each cycle:
  - If sel < CHANNELS: y<=word[sel], y_sel<=sel, y_valid<=1.
  - If sel >= CHANNELS: y and y_sel hold their previous values, y_valid<=0.
  - Dwell counter and scan index forced to 0. wrap=0.
- Entering SCAN (first cycle with mode=1 after MANUAL or reset):
  - Output is channel 0: y<=word[0], y_sel<=0, y_valid<=1.
  - Dwell counter restarts at 0. A prior manual sel has no effect.
- SCAN, each cycle:
  - y<=word[index], y_sel<=index, y_valid<=1. The word is resampled every cycle, so live data changes propagate within a dwell.
  - Dwell counter increments.
  - When the counter equals DWELL-1: counter<=0 and index advances.
  - Index CHANNELS-1 advances to 0 (not to 2**SEL_W-1 range). That transition asserts wrap for exactly the cycle on which y_sel first shows 0.
  - Each channel is shown for exactly DWELL consecutive cycles. With DWELL=1 the index advances every cycle.
- hold=1 in SCAN:
  - Counter and index frozen. y continues to resample word[index]. No wrap asserted.
  - Releasing hold resumes from the frozen count, with no cycle lost or repeated.
- hold in MANUAL is ignored.
- mode 1->0 mid-dwell: next cycle shows manual sel. Scan position is discarded, and a later return to SCAN restarts at channel 0.
- Simultaneous hold=1 and counter at DWELL-1: hold wins, no advance.
- CHANNELS not a power of two: scan never visits indices >= CHANNELS.

Test Plan:
Common setup: WIDTH=5, CHANNELS=4, SEL_W=2, DWELL=3; words ch0=5'h01, ch1=5'h0A, ch2=5'h15, ch3=5'h1F.
1. Reset: hold rst=1 for 2 cycles with mode=1 and sel=2 -> y=0, y_sel=0, y_valid=0, wrap=0 while rst high.
2. Manual: mode=0, sel driven 3,1,0,2 on consecutive cycles -> one cycle later y=1F,0A,01,15 with y_sel=3,1,0,2 and y_valid=1 each cycle.
3. Scan:
   - Stimulus: release reset with mode=1, run 15 cycles.
   - y_sel sequence: 0,0,0,1,1,1,2,2,2,3,3,3,0,0,0; y follows the matching words.
   - wrap=1 only on cycle 13, the first 0 after 3.
4. Hold: in scan, assert hold on the second cycle of ch2 for 5 cycles -> y_sel stays 2 and y=15 throughout; after release, exactly 2 more ch2 cycles, then ch3.
5. Mode switch: switch to manual with sel=3 during ch1, then back to scan 2 cycles later -> y_sel 1 -> 3,3 -> 0 (scan restarts at 0, full 3-cycle dwell).
6. Parameter/out-of-range: rebuild with CHANNELS=3, SEL_W=2, DWELL=1.
   - Scan -> y_sel 0,1,2,0,1,2 with wrap on each 0 after 2.
   - Manual sel=3 -> y and y_sel hold the prior values, y_valid=0.
   - Changing ch2 data mid-scan -> new value appears within 1 cycle.
